// File: rtl/controle_pilha.sv
// Stack control unit: serves PUSH/POP requests from the main control unit,
// performs the data-memory access and hands the updated $rp back to the register bank.
module controle_pilha #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned RP_BASE     = 25,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] dado_push,
    input  logic [DATA_W-1:0] rp_atual,
    input  logic              limpa_erro,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              PilhaE,
    output logic [DATA_W-1:0] rp,
    output logic [DATA_W-1:0] dado_pop,
    output logic              pop_valido,
    output logic              ocupado,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [DATA_W-1:0] RP_VAZIO = DATA_W'(RP_BASE);
    localparam logic [DATA_W-1:0] RP_CHEIO = DATA_W'(RP_BASE + STACK_DEPTH);
    localparam logic [DATA_W-1:0] UM       = DATA_W'(1);

    typedef enum logic [2:0] {
        OCIOSO,
        PUSH_ESC,
        POP_LE,
        POP_ESPERA,
        ATUALIZA
    } estado_t;

    estado_t           estado;
    logic [DATA_W-1:0] rp_lat;

    // Outputs are loaded on entry to the state that owns them, so each pulse
    // lines up with its state and is stable by the falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado     <= OCIOSO;
            rp_lat     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            PilhaE     <= 1'b0;
            rp         <= '0;
            dado_pop   <= '0;
            pop_valido <= 1'b0;
            ocupado    <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            PilhaE     <= 1'b0;
            pop_valido <= 1'b0;

            // Clear first so a same-cycle error set below takes priority.
            if (limpa_erro) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end

            case (estado)
                OCIOSO: begin
                    if (push && !pop) begin
                        if (rp_atual == RP_CHEIO) begin
                            overflow <= 1'b1;
                        end else begin
                            rp_lat    <= rp_atual;
                            mem_we    <= 1'b1;
                            mem_addr  <= ADDR_W'(rp_atual);
                            mem_wdata <= dado_push;
                            ocupado   <= 1'b1;
                            estado    <= PUSH_ESC;
                        end
                    end else if (pop && !push) begin
                        if (rp_atual == RP_VAZIO) begin
                            underflow <= 1'b1;
                        end else begin
                            rp_lat   <= rp_atual;
                            mem_re   <= 1'b1;
                            mem_addr <= ADDR_W'(rp_atual - UM);
                            ocupado  <= 1'b1;
                            estado   <= POP_LE;
                        end
                    end
                end
                PUSH_ESC: begin
                    PilhaE <= 1'b1;
                    rp     <= rp_lat + UM;
                    estado <= ATUALIZA;
                end
                POP_LE: begin
                    estado <= POP_ESPERA;
                end
                POP_ESPERA: begin
                    // Read data is valid this cycle; it becomes visible with pop_valido.
                    dado_pop   <= mem_rdata;
                    pop_valido <= 1'b1;
                    PilhaE     <= 1'b1;
                    rp         <= rp_lat - UM;
                    estado     <= ATUALIZA;
                end
                ATUALIZA: begin
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
                default: begin
                    ocupado <= 1'b0;
                    estado  <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_pilha.sv
// Self-checking bench for controle_pilha: scoreboard of expected memory/bank
// events, a small stack model for popped data, and directed latency checks.
module tb_controle_pilha;

    logic        clock;
    logic        reset;
    logic        push;
    logic        pop;
    logic [31:0] dado_push;
    logic [31:0] rp_atual;
    logic        limpa_erro;
    logic [31:0] mem_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        PilhaE;
    logic [31:0] rp;
    logic [31:0] dado_pop;
    logic        pop_valido;
    logic        ocupado;
    logic        overflow;
    logic        underflow;

    controle_pilha dut (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .dado_push  (dado_push),
        .rp_atual   (rp_atual),
        .limpa_erro (limpa_erro),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .PilhaE     (PilhaE),
        .rp         (rp),
        .dado_pop   (dado_pop),
        .pop_valido (pop_valido),
        .ocupado    (ocupado),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [31:0] exp_rp[$];
    logic [31:0] exp_pop[$];
    logic [31:0] model_stk[$];

    int n_tests = 0;
    int n_fail  = 0;
    int we_count = 0;

    logic [31:0] mem [256];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous data memory: read data valid the cycle after mem_re.
    always @(posedge clock) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected event.
    always @(negedge clock) begin
        if (!reset) begin
            chk("strobe_excl", 32'(mem_we) + 32'(mem_re) + 32'(PilhaE) <= 32'd1 ? 32'd1 : 32'd0, 32'd1);
            if (mem_we) begin
                we_count++;
                if (exp_wr.size() == 0) chk("unexp_we", 32'(mem_we), 32'd0);
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("we_addr", 32'(mem_addr), 32'(e.a));
                    chk("we_data", mem_wdata, e.d);
                end
            end
            if (mem_re) begin
                if (exp_rd.size() == 0) chk("unexp_re", 32'(mem_re), 32'd0);
                else chk("re_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
            end
            if (PilhaE) begin
                if (exp_rp.size() == 0) chk("unexp_pilhae", 32'(PilhaE), 32'd0);
                else chk("rp_novo", rp, exp_rp.pop_front());
            end
            if (pop_valido) begin
                if (exp_pop.size() == 0) chk("unexp_pop_valido", 32'(pop_valido), 32'd0);
                else chk("dado_pop", dado_pop, exp_pop.pop_front());
            end
        end
    end

    // Waits from the first cycle after the request until ocupado drops;
    // returns that cycle index and the cycle index where PilhaE was seen.
    task automatic wait_idle(output int n, output int pe_at);
        n = 1;
        pe_at = 0;
        while (n < 12) begin
            if (PilhaE) pe_at = n;
            if (!ocupado) break;
            @(negedge clock);
            n++;
        end
    endtask

    task automatic do_push(input logic [31:0] d, input logic [31:0] r, input logic clr);
        int  n;
        int  pe_at;
        bit  full;
        full = (r == 32'd41);
        @(negedge clock);
        push = 1'b1; dado_push = d; rp_atual = r; limpa_erro = clr;
        if (!full) begin
            exp_wr.push_back({r[7:0], d});
            exp_rp.push_back(r + 32'd1);
            model_stk.push_back(d);
        end
        @(negedge clock);
        push = 1'b0; limpa_erro = 1'b0;
        chk("push_we", 32'(mem_we), full ? 32'd0 : 32'd1);
        wait_idle(n, pe_at);
        chk("push_ready_lat", 32'(n), full ? 32'd1 : 32'd3);
        chk("push_pilhae_lat", 32'(pe_at), full ? 32'd0 : 32'd2);
    endtask

    task automatic do_pop(input logic [31:0] r);
        int  n;
        int  pe_at;
        bit  vazio;
        vazio = (r == 32'd25);
        @(negedge clock);
        pop = 1'b1; rp_atual = r;
        if (!vazio) begin
            exp_rd.push_back(8'(r - 32'd1));
            exp_rp.push_back(r - 32'd1);
            exp_pop.push_back(model_stk.pop_back());
        end
        @(negedge clock);
        pop = 1'b0;
        chk("pop_re", 32'(mem_re), vazio ? 32'd0 : 32'd1);
        wait_idle(n, pe_at);
        chk("pop_ready_lat", 32'(n), vazio ? 32'd1 : 32'd4);
        chk("pop_pilhae_lat", 32'(pe_at), vazio ? 32'd0 : 32'd3);
    endtask

    task automatic clear_err();
        @(negedge clock);
        limpa_erro = 1'b1;
        @(negedge clock);
        limpa_erro = 1'b0;
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_underflow", 32'(underflow), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_strobes"}, 32'({mem_we, mem_re, PilhaE, pop_valido, ocupado, overflow, underflow}), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rp"}, rp, 32'd0);
        chk({tag, "_dado_pop"}, dado_pop, 32'd0);
    endtask

    initial begin
        int n;
        int pe_at;
        int we_before;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        reset = 1'b0; push = 1'b0; pop = 1'b0; limpa_erro = 1'b0;
        dado_push = '0; rp_atual = 32'd25;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Basic push then pop of the same word.
        do_push(32'hCAFE0001, 32'd25, 1'b0);
        do_pop(32'd26);
        chk("pop_word", dado_pop, 32'hCAFE0001);

        // Underflow on empty stack, then clear.
        do_pop(32'd25);
        chk("underflow_set", 32'(underflow), 32'd1);
        clear_err();

        // Simultaneous push and pop is a no-op.
        @(negedge clock);
        push = 1'b1; pop = 1'b1; rp_atual = 32'd25;
        @(negedge clock);
        push = 1'b0; pop = 1'b0;
        chk("pushpop_noop", 32'({mem_we, mem_re, PilhaE, ocupado, overflow, underflow}), 32'd0);

        // Fill to the limit, then overflow with a concurrent clear (set wins).
        for (int i = 0; i < 16; i++) do_push(32'h10000000 + 32'(i), 32'd25 + 32'(i), 1'b0);
        do_push(32'hDEAD0000, 32'd41, 1'b1);
        chk("overflow_set", 32'(overflow), 32'd1);
        clear_err();
        do_pop(32'd41);
        chk("pop_last_fill", dado_pop, 32'h1000000F);

        // Push re-requested while busy produces a single write.
        we_before = we_count;
        @(negedge clock);
        push = 1'b1; dado_push = 32'hA5A5_0001; rp_atual = 32'd40;
        exp_wr.push_back({8'd40, 32'hA5A5_0001});
        exp_rp.push_back(32'd41);
        model_stk.push_back(32'hA5A5_0001);
        @(negedge clock);
        dado_push = 32'h5A5A_0002;
        @(negedge clock);
        push = 1'b0;
        wait_idle(n, pe_at);
        chk("busy_push_idle", 32'(ocupado), 32'd0);
        chk("busy_push_writes", 32'(we_count - we_before), 32'd1);
        do_pop(32'd41);

        // Reset while waiting on the read: everything clears, no PilhaE follows.
        @(negedge clock);
        pop = 1'b1; rp_atual = 32'd40;
        exp_rd.push_back(8'd39);
        @(negedge clock);
        pop = 1'b0;
        chk("abort_re", 32'(mem_re), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1 chk_all_zero("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        do_push(32'hBEEF0002, 32'd40, 1'b0);
        do_pop(32'd41);
        chk("pop_after_reset", dado_pop, 32'hBEEF0002);

        repeat (2) @(negedge clock);
        chk("sb_empty", 32'(exp_wr.size() + exp_rd.size() + exp_rp.size() + exp_pop.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
